// File: rtl/viterbi_pkg.sv
// Shared types, code constants and helpers for the K=3, rate-1/2 Viterbi decoder.
package viterbi_pkg;

    // Trellis state {s1,s0}; s1 is the most recent past information bit.
    typedef logic [1:0] trellis_state_t;

    localparam logic [2:0]  G1         = 3'b111;
    localparam logic [2:0]  G0         = 3'b101;
    localparam int unsigned NUM_STATES = 4;
    localparam int unsigned INIT_PM    = 4;

    // Expected code symbol {c1,c0} when bit b is shifted in from state s.
    function automatic logic [1:0] branch_symbol(input trellis_state_t s, input logic b);
        logic [2:0] taps;
        taps = {b, s};
        return {^(taps & G1), ^(taps & G0)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2).
    function automatic logic [1:0] hamming2(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] d;
        d = x ^ y;
        return {d[1] & d[0], d[1] ^ d[0]};
    endfunction

endpackage

// File: rtl/viterbi_decoder_if.sv
// Symbol-in / bit-out stream bundle of the Viterbi decoder.
interface viterbi_decoder_if;

    logic [1:0] cin;
    logic       in_valid;
    logic       bout;
    logic       out_valid;

    modport master (output cin, output in_valid, input bout, input out_valid);
    modport slave  (input cin, input in_valid, output bout, output out_valid);

endinterface

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state; ties resolve to the {x,0} predecessor.
module viterbi_acs #(
    parameter int unsigned PM_W = 3
) (
    input  logic [PM_W-1:0] pm0,
    input  logic [PM_W-1:0] pm1,
    input  logic [1:0]      bm0,
    input  logic [1:0]      bm1,
    output logic [PM_W:0]   pm_new,
    output logic            dec
);

    localparam int unsigned SW = PM_W + 1;

    logic [PM_W:0] sum0;
    logic [PM_W:0] sum1;

    // Extend by one bit so the add never wraps before normalization.
    always_comb begin
        sum0   = SW'(pm0) + SW'(bm0);
        sum1   = SW'(pm1) + SW'(bm1);
        dec    = (sum1 < sum0);
        pm_new = dec ? sum1 : sum0;
    end

endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder, 4-state trellis, register-exchange survivors.
// Optional macro VITERBI_BEST_STATE_EN: output taken from the minimum-metric
// survivor instead of the state-00 survivor.
module viterbi_decoder
    import viterbi_pkg::*;
#(
    parameter int unsigned TB_DEPTH = 15,
    parameter int unsigned PM_W     = 3
) (
    input  logic             ck,
    input  logic             rset,
    viterbi_decoder_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(TB_DEPTH + 1);

    logic [PM_W-1:0]     pm_q      [NUM_STATES];
    logic [PM_W-1:0]     pm_next   [NUM_STATES];
    logic [PM_W:0]       acs_pm    [NUM_STATES];
    logic                acs_dec   [NUM_STATES];
    logic [1:0]          bm        [NUM_STATES][2];
    logic [TB_DEPTH-1:0] surv_q    [NUM_STATES];
    logic [TB_DEPTH-1:0] surv_next [NUM_STATES];
    logic [PM_W:0]       pm_min;
    logic [CNT_W-1:0]    fill_q;
    logic                full;
    trellis_state_t      sel;

    // Branch metric for every (predecessor state, input bit) transition.
    always_comb begin
        for (int unsigned p = 0; p < NUM_STATES; p++) begin
            for (int unsigned b = 0; b < 2; b++) begin
                bm[p][b] = hamming2(bus.cin, branch_symbol(trellis_state_t'(p), 1'(b)));
            end
        end
    end

    // New state {b,x} has predecessors {x,0} and {x,1}.
    for (genvar s = 0; s < NUM_STATES; s++) begin : g_acs
        localparam int unsigned X = s % 2;
        localparam int unsigned B = s / 2;

        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm0    (pm_q[2*X]),
            .pm1    (pm_q[2*X+1]),
            .bm0    (bm[2*X][B]),
            .bm1    (bm[2*X+1][B]),
            .pm_new (acs_pm[s]),
            .dec    (acs_dec[s])
        );
    end

    // Rebase metrics so the best one is 0; the bounded spread then fits PM_W bits.
    always_comb begin
        pm_min = acs_pm[0];
        for (int unsigned s = 1; s < NUM_STATES; s++) begin
            if (acs_pm[s] < pm_min) pm_min = acs_pm[s];
        end
        for (int unsigned s = 0; s < NUM_STATES; s++) begin
            pm_next[s] = PM_W'(acs_pm[s] - pm_min);
        end
    end

    // Each survivor inherits its winning predecessor's history plus the new bit s1.
    always_comb begin
        for (int unsigned s = 0; s < NUM_STATES; s++) begin
            surv_next[s] = {surv_q[{s[0], acs_dec[s]}][TB_DEPTH-2:0], s[1]};
        end
    end

    // Metric and survivor registers; hold while no symbol is accepted.
    always_ff @(posedge ck or posedge rset) begin
        if (rset) begin
            for (int unsigned s = 0; s < NUM_STATES; s++) begin
                pm_q[s]   <= (s == 0) ? '0 : PM_W'(INIT_PM);
                surv_q[s] <= '0;
            end
        end else if (bus.in_valid) begin
            pm_q   <= pm_next;
            surv_q <= surv_next;
        end
    end

`ifdef VITERBI_BEST_STATE_EN
    trellis_state_t best_next;
    trellis_state_t best_q;

    // Lowest-index state holding the minimum new metric.
    always_comb begin
        best_next = '0;
        for (int unsigned s = 1; s < NUM_STATES; s++) begin
            if (acs_pm[s] < acs_pm[best_next]) best_next = trellis_state_t'(s);
        end
    end

    // Best state tracks the metric registers so it describes the current survivors.
    always_ff @(posedge ck or posedge rset) begin
        if (rset) begin
            best_q <= '0;
        end else if (bus.in_valid) begin
            best_q <= best_next;
        end
    end

    // Output survivor selection.
    always_comb begin
        sel = best_q;
    end
`else
    // Output survivor selection.
    always_comb begin
        sel = '0;
    end
`endif

    // Fill counter saturating at the survivor depth.
    always_ff @(posedge ck or posedge rset) begin
        if (rset) begin
            fill_q <= '0;
        end else if (bus.in_valid && !full) begin
            fill_q <= fill_q + 1'b1;
        end
    end

    // Survivors are only trustworthy once D symbols have been absorbed.
    always_comb begin
        full = (fill_q == CNT_W'(TB_DEPTH));
    end

    // Registered output from the oldest bit of the selected pre-update survivor.
    always_ff @(posedge ck or posedge rset) begin
        if (rset) begin
            bus.bout      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid && full;
            if (bus.in_valid) bus.bout <= surv_q[sel][TB_DEPTH-1];
        end
    end

endmodule
